// File: rtl/csr_access_unit_if.sv
// Request/response channel between the execute stage and the CSR access unit,
// plus the unit's port onto the CSR register file.
interface csr_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic [2:0]            req_funct3_in;
  logic [ADDR_WIDTH-1:0] req_addr_in;
  logic [4:0]            req_rs1_idx_in;
  logic [DATA_WIDTH-1:0] req_rs1_data_in;

  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [DATA_WIDTH-1:0] rsp_data_out;
  logic                  rsp_illegal_out;

  logic [ADDR_WIDTH-1:0] csr_addr_out;
  logic                  csr_wr_en_out;
  logic [DATA_WIDTH-1:0] csr_wr_data_out;
  logic [DATA_WIDTH-1:0] csr_wr_mask_out;
  logic [DATA_WIDTH-1:0] csr_rd_data_in;

  // Execute stage plus CSR file side.
  modport master (
    output req_valid_in, req_funct3_in, req_addr_in, req_rs1_idx_in, req_rs1_data_in,
    output rsp_ready_in, csr_rd_data_in,
    input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_illegal_out,
    input  csr_addr_out, csr_wr_en_out, csr_wr_data_out, csr_wr_mask_out
  );

  // The access unit itself.
  modport slave (
    input  req_valid_in, req_funct3_in, req_addr_in, req_rs1_idx_in, req_rs1_data_in,
    input  rsp_ready_in, csr_rd_data_in,
    output req_ready_out, rsp_valid_out, rsp_data_out, rsp_illegal_out,
    output csr_addr_out, csr_wr_en_out, csr_wr_data_out, csr_wr_mask_out
  );
endinterface

// File: rtl/csr_access_unit.sv
// Executes one Zicsr instruction per request: read the old CSR value, optionally
// write the new one through a data/mask pair, then return the old value for rd.
module csr_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input logic               clk,
  input logic               arst_n,
  csr_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  typedef enum logic [1:0] {OP_BAD = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} op_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            rs1_idx_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [DATA_WIDTH-1:0] old_q;

  op_e                   op;
  logic [DATA_WIDTH-1:0] src;
  logic                  write_req;
  logic                  illegal;
  logic                  write_go;
  logic                  accept;

  assign op  = op_e'(funct3_q[1:0]);
  assign src = funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  // Set/clear with rs1 = x0 (or uimm = 0) is a pure read.
  assign write_req = (op == OP_RW) || (rs1_idx_q != 5'd0);
  assign illegal   = (op == OP_BAD) ||
                     (write_req && (addr_q[ADDR_WIDTH-1 -: 2] == 2'b11));
  assign write_go  = write_req && !illegal;
  assign accept    = (state_q == IDLE) && bus.req_valid_in;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!arst_n) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      old_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q   <= bus.req_funct3_in;
        addr_q     <= bus.req_addr_in;
        rs1_idx_q  <= bus.req_rs1_idx_in;
        rs1_data_q <= bus.req_rs1_data_in;
      end
      if (state_q == READ) begin
        old_q <= illegal ? '0 : bus.csr_rd_data_in;
      end
    end
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d             = state_q;
    bus.req_ready_out   = 1'b0;
    bus.rsp_valid_out   = 1'b0;
    bus.rsp_data_out    = '0;
    bus.rsp_illegal_out = 1'b0;
    bus.csr_addr_out    = '0;
    bus.csr_wr_en_out   = 1'b0;
    bus.csr_wr_data_out = '0;
    bus.csr_wr_mask_out = '0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready_out = 1'b1;
        if (bus.req_valid_in) state_d = READ;
      end
      READ: begin
        bus.csr_addr_out = addr_q;
        state_d          = write_go ? WRITE : RESP;
      end
      WRITE: begin
        bus.csr_addr_out  = addr_q;
        // Reset is synchronous, so the file would still see this cycle's strobe
        // at the reset edge; gating it keeps a dropped request from writing.
        bus.csr_wr_en_out = arst_n;
        unique case (op)
          OP_RS: begin
            bus.csr_wr_data_out = '1;
            bus.csr_wr_mask_out = src;
          end
          OP_RC: begin
            bus.csr_wr_data_out = '0;
            bus.csr_wr_mask_out = src;
          end
          default: begin
            bus.csr_wr_data_out = src;
            bus.csr_wr_mask_out = '1;
          end
        endcase
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid_out   = 1'b1;
        bus.rsp_data_out    = old_q;
        bus.rsp_illegal_out = illegal;
        if (bus.rsp_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
